// File: rtl/bankswitch_scan_ctrl_if.sv
// Shared ROM read port between the bank-switch scan controller and the
// loader/CPU memory arbiter.
//   mem_rd    : read request from the controller, held until mem_valid
//   mem_addr  : byte address, stable while mem_rd is high
//   mem_data  : read data, qualified by mem_valid
//   mem_valid : read complete; the arbiter may hold it low to stall the scan
// master = scan controller, slave = memory/arbiter side.
interface bankswitch_scan_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_valid;

    modport master (output mem_rd, output mem_addr, input mem_data, input mem_valid);
    modport slave  (input mem_rd, input mem_addr, output mem_data, output mem_valid);
endinterface

// File: rtl/bankswitch_scan_ctrl.sv
// Bank-switch signature scan controller. After a ROM image is loaded it walks
// the image byte by byte through the shared read port, strobes each byte into
// the signature detectors, accumulates their match flags and reports a
// prioritised bank-switch scheme code to the cartridge mapper.
//   clk, reset     : clock, synchronous active-high reset
//   start_i        : one-cycle scan request (ignored while busy)
//   rom_size_i     : image length in bytes, sampled on an accepted start
//   mem            : ROM read port (master side)
//   det_clear_o    : one-cycle clear pulse to the detectors
//   det_ena_o      : one-cycle byte strobe, with det_addr_o / det_data_o
//   det_match_i    : detector match outputs
//   busy_o, done_o : scan in progress / result valid (level)
//   match_flags_o  : sticky OR of det_match_i over the scan
//   scheme_o       : 0 = no signature, else lowest set flag index + 1
module bankswitch_scan_ctrl #(
    parameter int ADDR_W    = 15,
    parameter int NUM_DET   = 8,
    parameter int MATCH_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_W:0]       rom_size_i,
    bankswitch_scan_ctrl_if.master mem,
    output logic                  det_clear_o,
    output logic                  det_ena_o,
    output logic [ADDR_W-1:0]     det_addr_o,
    output logic [7:0]            det_data_o,
    input  logic [NUM_DET-1:0]    det_match_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NUM_DET-1:0]    match_flags_o,
    output logic [3:0]            scheme_o
);
    localparam int CNT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
    localparam logic [ADDR_W:0] MAX_SIZE = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_REQ, S_PRESENT, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     size_q, size_d;
    // One bit wider than the address so a full 2^ADDR_W image never wraps.
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   det_addr_q, det_addr_d;
    logic [7:0]          det_data_q, det_data_d;
    logic [NUM_DET-1:0]  flags_q, flags_d;
    logic [3:0]          scheme_q, scheme_d;
    logic                done_q, done_d;

    // Bit 0 has the highest priority.
    function automatic logic [3:0] prio_enc(input logic [NUM_DET-1:0] f);
        logic [3:0] s;
        s = 4'd0;
        for (int i = NUM_DET - 1; i >= 0; i--) begin
            if (f[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            det_addr_q <= '0;
            det_data_q <= '0;
            flags_q    <= '0;
            scheme_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            det_addr_q <= det_addr_d;
            det_data_q <= det_data_d;
            flags_q    <= flags_d;
            scheme_q   <= scheme_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        det_addr_d = det_addr_q;
        det_data_d = det_data_q;
        scheme_d   = scheme_q;
        done_d     = done_q;
        // Matches are only trusted after det_clear; stale detector state
        // seen in IDLE/CLEAR/DONE is masked out.
        flags_d    = flags_q;
        if (state_q == S_REQ || state_q == S_PRESENT || state_q == S_DRAIN)
            flags_d = flags_q | det_match_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    size_d   = (rom_size_i > MAX_SIZE) ? MAX_SIZE : rom_size_i;
                    flags_d  = '0;
                    scheme_d = '0;
                    done_d   = 1'b0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ptr_d   = '0;
                cnt_d   = '0;
                state_d = (size_q == '0) ? S_DRAIN : S_REQ;
            end
            S_REQ: begin
                if (mem.mem_valid) begin
                    det_addr_d = ptr_q[ADDR_W-1:0];
                    det_data_d = mem.mem_data;
                    state_d    = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ptr_q == size_q - (ADDR_W+1)'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    ptr_d   = ptr_q + (ADDR_W+1)'(1);
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                // Encode from flags_d so a match landing in the last drain
                // cycle still reaches the scheme code.
                if (cnt_q == CNT_W'(MATCH_LAT - 1)) begin
                    scheme_d = prio_enc(flags_d);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem.mem_rd    = (state_q == S_REQ);
    assign mem.mem_addr  = ptr_q[ADDR_W-1:0];
    assign det_clear_o   = (state_q == S_CLEAR);
    assign det_ena_o     = (state_q == S_PRESENT);
    assign det_addr_o    = det_addr_q;
    assign det_data_o    = det_data_q;
    assign busy_o        = (state_q == S_CLEAR) || (state_q == S_REQ) ||
                           (state_q == S_PRESENT) || (state_q == S_DRAIN);
    assign done_o        = done_q;
    assign match_flags_o = flags_q;
    assign scheme_o      = scheme_q;
endmodule

// File: tb/tb_bankswitch_scan_ctrl.sv
module tb_bankswitch_scan_ctrl;
    localparam int ADDR_W    = 15;
    localparam int NUM_DET   = 8;
    localparam int MATCH_LAT = 2;
    localparam int ROM_MAX   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W:0]     rom_size = '0;
    logic                det_clear, det_ena, busy, done;
    logic [ADDR_W-1:0]   det_addr;
    logic [7:0]          det_data;
    logic [NUM_DET-1:0]  det_match;
    logic [NUM_DET-1:0]  match_flags;
    logic [3:0]          scheme;

    bankswitch_scan_ctrl_if #(.ADDR_W(ADDR_W)) mif();

    bankswitch_scan_ctrl #(.ADDR_W(ADDR_W), .NUM_DET(NUM_DET), .MATCH_LAT(MATCH_LAT)) dut (
        .clk(clk), .reset(reset), .start_i(start), .rom_size_i(rom_size), .mem(mif),
        .det_clear_o(det_clear), .det_ena_o(det_ena), .det_addr_o(det_addr),
        .det_data_o(det_data), .det_match_i(det_match), .busy_o(busy), .done_o(done),
        .match_flags_o(match_flags), .scheme_o(scheme)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } byte_t;
    typedef struct { logic [7:0] flags; logic [3:0] scheme; int lat; } res_t;

    logic [7:0] img [0:ROM_MAX-1];
    byte_t exp_b[$];
    res_t  exp_r[$];
    int    total = 0, bad = 0;

    bit    trig_en   [NUM_DET];
    int    trig_addr [NUM_DET];
    int    wait_min = 0, wait_max = 0;
    bit    noise_on = 0;
    bit    ena_seen = 0;
    logic [ADDR_W-1:0] addr_seen = '0;
    int    ena_cnt = 0, clr_cnt = 0, rd_cnt = 0, cyc = 0, start_cyc = 0;
    bit    rd_active = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic  done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_scheme(input logic [7:0] f);
        for (int k = 0; k < NUM_DET; k++) if (f[k]) return 4'(k + 1);
        return 4'd0;
    endfunction

    // Memory/arbiter model: random wait states in [wait_min, wait_max].
    initial begin
        int wcnt;
        wcnt = 0;
        mif.mem_valid = 1'b0;
        mif.mem_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!mif.mem_rd) begin
                mif.mem_valid = 1'b0;
                wcnt = $urandom_range(wait_min, wait_max);
            end else if (!mif.mem_valid) begin
                if (wcnt == 0) begin
                    mif.mem_valid = 1'b1;
                    mif.mem_data  = img[mif.mem_addr];
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Detector model: bit k fires the cycle after the strobe at trig_addr[k];
    // while idle it may spray noise that must be ignored.
    initial begin
        logic [NUM_DET-1:0] m;
        det_match = '0;
        forever begin
            @(posedge clk); #1;
            m = '0;
            if (ena_seen)
                for (int k = 0; k < NUM_DET; k++)
                    if (trig_en[k] && trig_addr[k] == int'(addr_seen)) m[k] = 1'b1;
            if (!busy && noise_on) m = NUM_DET'($urandom);
            det_match = m;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        byte_t b;
        res_t  r;
        cyc++;
        ena_seen  = det_ena;
        addr_seen = det_addr;
        if (start && !busy && !reset) start_cyc = cyc;
        if (det_clear) clr_cnt++;
        if (mif.mem_rd) begin
            if (rd_active) chk("mem_addr_stable", 32'(mif.mem_addr), 32'(rd_addr));
            rd_active = !mif.mem_valid;
            rd_addr   = mif.mem_addr;
            if (mif.mem_valid) rd_cnt++;
        end else begin
            rd_active = 0;
        end
        if (det_ena) begin
            ena_cnt++;
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL det_ena_unexpected: got addr %0h expected no strobe", det_addr);
            end else begin
                b = exp_b.pop_front();
                chk("det_addr", 32'(det_addr), 32'(b.addr));
                chk("det_data", 32'(det_data), 32'(b.data));
            end
        end
        if (done && !done_prev) begin
            if (exp_r.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got done=1 expected no result");
            end else begin
                r = exp_r.pop_front();
                chk("match_flags", 32'(match_flags), 32'(r.flags));
                chk("scheme", 32'(scheme), 32'(r.scheme));
                if (r.lat >= 0) chk("done_latency", 32'(cyc - start_cyc), 32'(r.lat));
            end
        end
        done_prev = done;
    end

    task automatic clr_trig();
        for (int k = 0; k < NUM_DET; k++) begin
            trig_en[k] = 0;
            trig_addr[k] = 0;
        end
    endtask

    task automatic run_scan(input int size_req, input int wmin, input int wmax,
                            input bit lat_chk, input bit mid_start);
        int sz, e0, c0, r0, n, budget;
        logic [7:0] f;
        res_t  r;
        byte_t b;
        sz = (size_req > ROM_MAX) ? ROM_MAX : size_req;
        f = '0;
        for (int k = 0; k < NUM_DET; k++)
            if (trig_en[k] && trig_addr[k] < sz) f[k] = 1'b1;
        for (int a = 0; a < sz; a++) begin
            b.addr = ADDR_W'(a);
            b.data = img[a];
            exp_b.push_back(b);
        end
        r.flags  = f;
        r.scheme = ref_scheme(f);
        r.lat    = lat_chk ? (1 + 2 * sz + MATCH_LAT + 1) : -1;
        exp_r.push_back(r);
        wait_min = wmin;
        wait_max = wmax;
        @(posedge clk); #1;
        e0 = ena_cnt; c0 = clr_cnt; r0 = rd_cnt;
        start = 1'b1;
        rom_size = (ADDR_W+1)'(size_req);
        @(posedge clk); #1;
        start = 1'b0;
        if (mid_start) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            rom_size = (ADDR_W+1)'(3);
            @(posedge clk); #1;
            start = 1'b0;
        end
        budget = 2 * sz * (wmax + 2) + 40;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
        @(posedge clk); #1;
        chk("ena_count", 32'(ena_cnt - e0), 32'(sz));
        chk("clear_count", 32'(clr_cnt - c0), 32'd1);
        chk("read_count", 32'(rd_cnt - r0), 32'(sz));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("flags_hold", 32'(match_flags), 32'(f));
        chk("bytes_left", 32'(exp_b.size()), 32'd0);
    endtask

    initial begin
        int n;
        clr_trig();
        for (int a = 0; a < ROM_MAX; a++) img[a] = 8'($urandom);

        // Reset with a coincident start: reset must win.
        start = 1'b1;
        rom_size = (ADDR_W+1)'(4);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({mif.mem_rd, det_clear, det_ena, busy, done, scheme, match_flags}), 32'd0);
        chk("rst_data", 32'({det_addr, det_data}), 32'd0);
        chk("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        // Image 8D E0 1F 00, det_match[0] after the byte at addr 2.
        img[0] = 8'h8D; img[1] = 8'hE0; img[2] = 8'h1F; img[3] = 8'h00;
        trig_en[0] = 1; trig_addr[0] = 2;
        run_scan(4, 0, 0, 1, 0);

        // Slow memory, no matches.
        clr_trig();
        run_scan(8, 3, 3, 0, 0);

        // Two detectors, bit 2 must win priority over bit 5.
        clr_trig();
        trig_en[5] = 1; trig_addr[5] = 1;
        trig_en[2] = 1; trig_addr[2] = 6;
        run_scan(8, 0, 0, 1, 0);

        // Empty image, with idle noise on det_match that must be masked.
        clr_trig();
        noise_on = 1;
        run_scan(0, 0, 0, 1, 0);

        // Start pulsed mid-scan is ignored.
        trig_en[3] = 1; trig_addr[3] = 9;
        run_scan(10, 1, 1, 0, 1);

        // Reset while a read is outstanding, then a fresh scan.
        clr_trig();
        wait_min = 2; wait_max = 2;
        @(posedge clk); #1;
        start = 1'b1;
        rom_size = (ADDR_W+1)'(16);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!mif.mem_rd && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_before_reset", 32'(mif.mem_rd), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ctrl", 32'({mif.mem_rd, det_clear, det_ena, busy, done, scheme, match_flags}), 32'd0);
        chk("midrst_data", 32'({det_addr, det_data}), 32'd0);
        reset = 1'b0;
        exp_b.delete();
        exp_r.delete();
        trig_en[1] = 1; trig_addr[1] = 0;
        run_scan(5, 0, 2, 0, 0);

        // Randomised scans.
        for (int it = 0; it < 8; it++) begin
            clr_trig();
            for (int k = 0; k < NUM_DET; k++) begin
                trig_en[k]   = bit'($urandom_range(0, 1));
                trig_addr[k] = $urandom_range(0, 47);
            end
            run_scan($urandom_range(1, 40), 0, $urandom_range(0, 3), 0, 0);
        end

        // Full 32 KiB image; a match on the very last byte lands in drain.
        clr_trig();
        noise_on = 0;
        trig_en[7] = 1; trig_addr[7] = ROM_MAX - 1;
        run_scan(ROM_MAX, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
